// File: rtl/cv32e40p_xilinx_soc.sv
// cv32e40p_xilinx_soc: IEEE 1149.1 TAP oversampled in the clk_i domain.
// Provides IDCODE and BYPASS data registers plus a MEMACC register that
// reads and writes a small on-chip word RAM through JTAG.
module cv32e40p_xilinx_soc #(
    parameter logic [31:0] IDCODE_VAL = 32'h249511C3,
    parameter int unsigned RAM_WORDS  = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic tck_i,
    input  logic tms_i,
    input  logic td_i,
    input  logic trst_ni,
    output logic td_o
);
    typedef enum logic [3:0] {
        TEST_LOGIC_RESET, RUN_TEST_IDLE,
        SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
        SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
    } tap_state_e;

    // Any IR code other than these two selects the 1-bit BYPASS register.
    localparam logic [4:0]  IR_IDCODE = 5'h01;
    localparam logic [4:0]  IR_MEMACC = 5'h10;
    localparam logic [1:0]  OP_READ   = 2'b01;
    localparam logic [1:0]  OP_WRITE  = 2'b10;
    // The RAM array is rounded up to a power of two; words at or above
    // RAM_WORDS exist physically but are never accessed.
    localparam int unsigned ADDR_BITS = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int unsigned MEM_DEPTH = 1 << ADDR_BITS;
    localparam logic [8:0]  RAM_LIMIT = 9'(RAM_WORDS);

    logic [1:0]           tck_sync, tms_sync, tdi_sync, trst_sync;
    logic                 tck_q;
    logic                 tck_rise, tck_fall, trst_active, tms_s, tdi_s;
    tap_state_e           state_q, state_d;
    logic                 capture_ir, shift_ir, update_ir;
    logic                 capture_dr, shift_dr, update_dr;
    logic [4:0]           ir_q, ir_shift_q;
    logic [41:0]          dr_shift_q, dr_capture, dr_shifted;
    logic [7:0]           last_addr_q;
    logic [31:0]          last_rdata_q;
    logic [7:0]           mem_addr;
    logic [1:0]           mem_op;
    logic                 mem_in_range, mem_access, mem_we;
    logic [ADDR_BITS-1:0] mem_idx;
    logic [31:0]          mem [MEM_DEPTH];
    logic [31:0]          mem_rdata_q;
    logic                 rd_pend_q, rd_in_range_q;

    assign tck_rise    = tck_sync[1] & ~tck_q;
    assign tck_fall    = ~tck_sync[1] & tck_q;
    assign trst_active = ~trst_sync[1];
    assign tms_s       = tms_sync[1];
    assign tdi_s       = tdi_sync[1];

    // Two-flop synchronizers for every JTAG pin, plus a third tck flop for edges.
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // flops sample the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_q     <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], tck_i};
            tms_sync  <= {tms_sync[0], tms_i};
            tdi_sync  <= {tdi_sync[0], td_i};
            trst_sync <= {trst_sync[0], trst_ni};
            tck_q     <= tck_sync[1];
        end
    end

    // TAP state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= TEST_LOGIC_RESET;
        else       state_q <= state_d;
    end

    // TAP next state and the single-cycle capture/shift/update strobes.
    // NOTE: every output gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        capture_ir = 1'b0;
        shift_ir   = 1'b0;
        update_ir  = 1'b0;
        capture_dr = 1'b0;
        shift_dr   = 1'b0;
        update_dr  = 1'b0;
        if (trst_active) begin
            state_d = TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            capture_ir = (state_q == CAPTURE_IR);
            shift_ir   = (state_q == SHIFT_IR);
            capture_dr = (state_q == CAPTURE_DR);
            shift_dr   = (state_q == SHIFT_DR);
            case (state_q)
                TEST_LOGIC_RESET: state_d = tms_s ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
                RUN_TEST_IDLE:    state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_DR:        state_d = tms_s ? SELECT_IR : CAPTURE_DR;
                CAPTURE_DR:       state_d = tms_s ? EXIT1_DR : SHIFT_DR;
                SHIFT_DR:         state_d = tms_s ? EXIT1_DR : SHIFT_DR;
                EXIT1_DR:         state_d = tms_s ? UPDATE_DR : PAUSE_DR;
                PAUSE_DR:         state_d = tms_s ? EXIT2_DR : PAUSE_DR;
                EXIT2_DR:         state_d = tms_s ? UPDATE_DR : SHIFT_DR;
                UPDATE_DR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                SELECT_IR:        state_d = tms_s ? TEST_LOGIC_RESET : CAPTURE_IR;
                CAPTURE_IR:       state_d = tms_s ? EXIT1_IR : SHIFT_IR;
                SHIFT_IR:         state_d = tms_s ? EXIT1_IR : SHIFT_IR;
                EXIT1_IR:         state_d = tms_s ? UPDATE_IR : PAUSE_IR;
                PAUSE_IR:         state_d = tms_s ? EXIT2_IR : PAUSE_IR;
                EXIT2_IR:         state_d = tms_s ? UPDATE_IR : SHIFT_IR;
                UPDATE_IR:        state_d = tms_s ? SELECT_DR : RUN_TEST_IDLE;
                default:          state_d = TEST_LOGIC_RESET;
            endcase
            // Update states never loop on themselves, so this marks entry.
            update_ir = (state_d == UPDATE_IR);
            update_dr = (state_d == UPDATE_DR);
        end
    end

    // Capture value and one-step shift of the DR selected by IR; td_i enters
    // at the MSB of the selected register's length.
    always_comb begin
        dr_capture = '0;
        dr_shifted = {41'b0, tdi_s};
        case (ir_q)
            IR_IDCODE: begin
                dr_capture = {10'b0, IDCODE_VAL};
                dr_shifted = {10'b0, tdi_s, dr_shift_q[31:1]};
            end
            IR_MEMACC: begin
                dr_capture = {last_addr_q, last_rdata_q, 2'b00};
                dr_shifted = {tdi_s, dr_shift_q[41:1]};
            end
            default: ;
        endcase
    end

    assign mem_addr     = dr_shift_q[41:34];
    assign mem_op       = dr_shift_q[1:0];
    assign mem_idx      = mem_addr[ADDR_BITS-1:0];
    assign mem_in_range = ({1'b0, mem_addr} < RAM_LIMIT);
    assign mem_access   = update_dr && (ir_q == IR_MEMACC);
    assign mem_we       = mem_access && (mem_op == OP_WRITE) && mem_in_range && !rst_i;

    // IR, shift registers, MEMACC result registers and the td_o output flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ir_q          <= IR_IDCODE;
            ir_shift_q    <= '0;
            dr_shift_q    <= '0;
            last_addr_q   <= '0;
            last_rdata_q  <= '0;
            rd_pend_q     <= 1'b0;
            rd_in_range_q <= 1'b0;
            td_o          <= 1'b0;
        end else begin
            if (state_d == TEST_LOGIC_RESET) ir_q <= IR_IDCODE;
            else if (update_ir)              ir_q <= ir_shift_q;

            if (capture_ir)    ir_shift_q <= 5'b00001;
            else if (shift_ir) ir_shift_q <= {tdi_s, ir_shift_q[4:1]};

            if (capture_dr)    dr_shift_q <= dr_capture;
            else if (shift_dr) dr_shift_q <= dr_shifted;

            if (mem_access && (mem_op == OP_READ || mem_op == OP_WRITE))
                last_addr_q <= mem_addr;
            rd_pend_q     <= mem_access && (mem_op == OP_READ);
            rd_in_range_q <= mem_in_range;
            if (rd_pend_q)
                last_rdata_q <= rd_in_range_q ? mem_rdata_q : 32'h0;

            if (trst_active)
                td_o <= 1'b0;
            else if (tck_fall)
                td_o <= (state_q == SHIFT_IR) ? ir_shift_q[0] :
                        (state_q == SHIFT_DR) ? dr_shift_q[0] : 1'b0;
        end
    end

    // Word RAM with a registered read port.
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // block/distributed RAM and keeps its contents across rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_idx] <= dr_shift_q[33:2];
        mem_rdata_q <= mem[mem_idx];
    end
endmodule

// File: tb/tb_cv32e40p_xilinx_soc.sv
// Self-checking bench for cv32e40p_xilinx_soc. A transaction-level JTAG
// model predicts every td_o bit as a serial stream (captured bits followed by
// the bits shifted in); a compare process checks td_o on every clk_i cycle.
module tb_cv32e40p_xilinx_soc;
    localparam logic [31:0] IDCODE    = 32'h249511C3;
    localparam int          RAM_WORDS = 128;
    localparam int          PH        = 6;   // clk_i cycles per tck phase

    logic clk_i   = 1'b0;
    logic rst_i   = 1'b1;
    logic tck_i   = 1'b0;
    logic tms_i   = 1'b1;
    logic td_i    = 1'b0;
    logic trst_ni = 1'b0;
    logic td_o;

    cv32e40p_xilinx_soc #(
        .IDCODE_VAL(IDCODE),
        .RAM_WORDS (RAM_WORDS)
    ) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .tck_i  (tck_i),
        .tms_i  (tms_i),
        .td_i   (td_i),
        .trst_ni(trst_ni),
        .td_o   (td_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;
    logic        exp_td = 1'b0;
    logic        obs_q[$];
    logic [63:0] obs;

    // Model state
    logic [4:0]  m_ir;
    logic [7:0]  m_last_addr;
    logic [31:0] m_last_rdata;
    logic [31:0] m_ram [int];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare td_o against the model on every cycle it is settled.
    always @(negedge clk_i) begin
        if (chk_en) check("td_o", 64'(td_o), 64'(exp_td));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        m_ir         = 5'h01;
        m_last_addr  = 8'h0;
        m_last_rdata = 32'h0;
    endtask

    function automatic int dr_len_model();
        if (m_ir == 5'h01) return 32;
        if (m_ir == 5'h10) return 42;
        return 1;
    endfunction

    function automatic logic [41:0] dr_capture_model();
        if (m_ir == 5'h01) return {10'h0, IDCODE};
        if (m_ir == 5'h10) return {m_last_addr, m_last_rdata, 2'b00};
        return 42'h0;
    endfunction

    task automatic mem_update(input logic [41:0] f);
        int          a;
        logic [1:0]  op;
        a  = int'(f[41:34]);
        op = f[1:0];
        if (op == 2'b10) begin
            if (a < RAM_WORDS) m_ram[a] = f[33:2];
            m_last_addr = f[41:34];
        end else if (op == 2'b01) begin
            m_last_rdata = (a < RAM_WORDS && m_ram.exists(a)) ? m_ram[a] : 32'h0;
            m_last_addr  = f[41:34];
        end
    endtask

    function automatic logic [41:0] mk(input logic [7:0] a, input logic [31:0] d, input logic [1:0] op);
        return {a, d, op};
    endfunction

    function automatic logic [63:0] obs_bits(input int cnt);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < cnt && i < obs_q.size(); i++) r[i] = obs_q[i];
        return r;
    endfunction

    // One full tck period; exp_v is td_o expected after the falling edge.
    task automatic tck_pulse(input logic tms_v, input logic tdi_v, input logic exp_v);
        tms_i = tms_v;
        td_i  = tdi_v;
        step(1);
        tck_i = 1'b1;
        step(PH);
        chk_en = 1'b0;
        tck_i  = 1'b0;
        step(PH);
        exp_td = exp_v;
        chk_en = 1'b1;
        obs_q.push_back(td_o);
    endtask

    // Scan from Run-Test/Idle; with abort set, stop while still shifting.
    task automatic scan(input bit is_ir, input logic [41:0] din, input int n, input bit abort);
        logic        q[$];
        logic [41:0] cap;
        logic [41:0] fin;
        int          len;
        if (is_ir) begin
            cap = 42'h1;
            len = 5;
        end else begin
            cap = dr_capture_model();
            len = dr_len_model();
        end
        for (int i = 0; i < len; i++) q.push_back(cap[i]);
        for (int i = 0; i < n; i++)   q.push_back(din[i]);
        tck_pulse(1'b1, 1'b0, 1'b0);
        if (is_ir) tck_pulse(1'b1, 1'b0, 1'b0);
        tck_pulse(1'b0, 1'b0, 1'b0);
        obs_q.delete();
        tck_pulse(1'b0, 1'b0, q[0]);
        for (int i = 0; i < n; i++) begin
            logic last;
            last = !abort && (i == n - 1);
            tck_pulse(last, din[i], last ? 1'b0 : q[i+1]);
        end
        if (abort) return;
        fin = '0;
        for (int j = 0; j < len; j++) fin[j] = q[n+j];
        tck_pulse(1'b1, 1'b0, 1'b0);
        if (is_ir) m_ir = fin[4:0];
        else if (m_ir == 5'h10) mem_update(fin);
        tck_pulse(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        // Reset with trst low, then release both; tck idle, td_o must stay 0.
        step(2);
        exp_td = 1'b0;
        chk_en = 1'b1;
        step(4);
        rst_i = 1'b0;
        step(4);
        trst_ni = 1'b1;
        step(8);

        // IDCODE via TMS 0,1,0,0 from Test-Logic-Reset.
        tck_pulse(1'b0, 1'b0, 1'b0);
        scan(1'b0, 42'h0, 32, 1'b0);
        check("idcode_bits", obs_bits(32), 64'(IDCODE));

        // BYPASS: shift 1,0,1,1 -> 0,1,0,1.
        scan(1'b1, 42'h1F, 5, 1'b0);
        scan(1'b0, 42'b1101, 4, 1'b0);
        check("bypass_bits", obs_bits(4), 64'hA);

        // MEMACC write, read, then capture.
        scan(1'b1, 42'h10, 5, 1'b0);
        scan(1'b0, mk(8'h05, 32'hDEADBEEF, 2'b10), 42, 1'b0);
        scan(1'b0, mk(8'h05, 32'h0, 2'b01), 42, 1'b0);
        scan(1'b0, mk(8'h7F, 32'h12345678, 2'b10), 42, 1'b0);
        obs = obs_bits(42);
        check("memacc_data", obs[33:2], 64'hDEADBEEF);
        check("memacc_addr", obs[41:34], 64'h05);
        check("memacc_op", obs[1:0], 64'h0);

        // Address range boundary: 0x7F is the last word, 0x85 is outside.
        scan(1'b0, mk(8'h85, 32'hCAFEF00D, 2'b10), 42, 1'b0);
        scan(1'b0, mk(8'h85, 32'h0, 2'b01), 42, 1'b0);
        scan(1'b0, mk(8'h7F, 32'h0, 2'b01), 42, 1'b0);
        obs = obs_bits(42);
        check("oob_read_data", obs[33:2], 64'h0);
        check("oob_read_addr", obs[41:34], 64'h85);
        scan(1'b0, mk(8'h05, 32'h0, 2'b01), 42, 1'b0);
        obs = obs_bits(42);
        check("top_word_data", obs[33:2], 64'h12345678);
        scan(1'b0, mk(8'h00, 32'h0, 2'b11), 42, 1'b0);
        obs = obs_bits(42);
        check("oob_write_ignored", obs[33:2], 64'hDEADBEEF);
        scan(1'b0, 42'h0, 42, 1'b0);
        obs = obs_bits(42);
        check("op11_no_action", obs[41:2], {24'h0, 8'h05, 32'hDEADBEEF});

        // trst during Shift-DR of a write.
        scan(1'b0, mk(8'h05, 32'h11111111, 2'b10), 20, 1'b1);
        chk_en  = 1'b0;
        trst_ni = 1'b0;
        step(PH);
        exp_td = 1'b0;
        chk_en = 1'b1;
        step(4);
        trst_ni = 1'b1;
        m_ir    = 5'h01;
        step(6);
        tck_pulse(1'b0, 1'b0, 1'b0);
        scan(1'b0, 42'h0, 32, 1'b0);
        check("idcode_after_trst", obs_bits(32), 64'(IDCODE));
        scan(1'b1, 42'h10, 5, 1'b0);
        scan(1'b0, mk(8'h05, 32'h0, 2'b01), 42, 1'b0);
        scan(1'b0, 42'h0, 42, 1'b0);
        obs = obs_bits(42);
        check("ram_after_trst", obs[33:2], 64'hDEADBEEF);

        // rst_i during Shift-DR of a write.
        scan(1'b0, mk(8'h05, 32'h22222222, 2'b10), 41, 1'b1);
        chk_en = 1'b0;
        rst_i  = 1'b1;
        step(1);
        exp_td = 1'b0;
        chk_en = 1'b1;
        step(3);
        rst_i = 1'b0;
        model_reset();
        step(6);
        tck_pulse(1'b0, 1'b0, 1'b0);
        scan(1'b1, 42'h10, 5, 1'b0);
        scan(1'b0, mk(8'h05, 32'h0, 2'b01), 42, 1'b0);
        check("capture_after_rst", obs_bits(42), 64'h0);
        scan(1'b0, 42'h0, 42, 1'b0);
        obs = obs_bits(42);
        check("ram_kept_over_rst", obs[33:2], 64'hDEADBEEF);

        // Undefined IR code behaves as BYPASS.
        scan(1'b1, 42'h0A, 5, 1'b0);
        scan(1'b0, 42'b1101, 4, 1'b0);
        check("undef_ir_bypass", obs_bits(4), 64'hA);

        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "timeout");
    end
endmodule
